dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: PRIO_MODE, default 0, 0 = round-robin, 1 = CPU fixed priority with DMA starvation guard.
REQ-002 Parameter: STARVE_LIMIT, default 4, consecutive DMA arbitration losses before DMA is forced to win (PRIO_MODE=1 only).
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: cpu_req in 1 / cpu_we in 1 / cpu_addr in 8 / cpu_wdata in 8  CPU access command.
REQ-006 Ports: cpu_gnt out 1 / cpu_rvalid out 1 / cpu_rdata out 8  CPU grant and read response.
REQ-007 Ports: dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata  same widths and meanings for the DMA port.
REQ-008 Ports: mem_write out 1 / mem_read out 1 / mem_addr out 8 / mem_wdata out 8  drive data memory (write on posedge, combinational read).
REQ-009 Port: mem_rdata  in  1x8  combinational read data from data memory.

Function
REQ-010 FSM SHALL have two states: IDLE and ACCESS.
REQ-011 IDLE: if any req is high at a rising edge, the arbiter SHALL latch the winner's we/addr/wdata and move to ACCESS; otherwise stay IDLE.
REQ-012 ACCESS SHALL last exactly one cycle, then return to IDLE unconditionally; maximum throughput is one access per 2 cycles.
REQ-013 During ACCESS: the winner's gnt=1, mem_addr/mem_wdata = latched values, mem_write = latched we, mem_read = !latched we.
REQ-014 Outside ACCESS: mem_write=0, mem_read=0, both gnt=0; mem_addr/mem_wdata hold the last latched values.
REQ-015 Requesters SHALL hold req and command stable until their gnt is sampled high; req still high during gnt is not re-arbitrated in that cycle.
REQ-016 Read: mem_rdata SHALL be captured into the winner's rdata register at the end of ACCESS; that port's rvalid=1 for exactly the following cycle.
REQ-017 rdata SHALL hold its value until that port's next read completes; writes never change rdata or assert rvalid.
REQ-018 Read latency: req sampled at edge E0 -> gnt in cycle E0..E1 -> rvalid in cycle E1..E2.
REQ-019 PRIO_MODE=0, both req: grant the port not granted last; last_grant resets to DMA, so CPU wins the first tie.
REQ-020 PRIO_MODE=1, both req: CPU wins unless the starvation counter equals STARVE_LIMIT, in which case DMA wins.
REQ-021 Starvation counter: increments (saturating at STARVE_LIMIT) when DMA loses an arbitration, clears when DMA is granted or dma_req is low in IDLE.
REQ-022 Single requester SHALL always be granted in either mode, regardless of history.

Reset
REQ-023 rst_n low SHALL immediately force: state=IDLE, all gnt/rvalid=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0, rdata=0, last_grant=DMA, starvation counter=0.
REQ-024 Reset during ACCESS SHALL abort the access; mem_write drops asynchronously so no write commits at the next edge.
REQ-025 Arbitration resumes at the first rising edge after rst_n deasserts.

Structure
REQ-026 Shared package dmem_arb_pkg SHALL hold the state enum (IDLE, ACCESS) and the port-id constants (PORT_CPU, PORT_DMA).
REQ-027 One sub-module dmem_arb_pick SHALL hold winner selection, last_grant, and the starvation counter; the FSM, command latch, and response registers stay in dmem_arbiter.

Verification
REQ-028 CPU write then read: cpu write addr 0x10 data 0xA5, then read 0x10 -> mem_write one cycle, then cpu_rvalid=1 with cpu_rdata=0xA5.
REQ-029 Round-robin (PRIO_MODE=0): both ports hold req for reads 0x01/0x02 -> grants alternate CPU, DMA, CPU, ...; mem_read high only in ACCESS cycles.
REQ-030 Starvation (PRIO_MODE=1, STARVE_LIMIT=4): both req held -> CPU granted 4 times, DMA on the 5th grant, then counter cleared.
REQ-031 Reset mid-write: assert rst_n low during DMA ACCESS writing 0x3C to 0x20 -> mem_write=0 immediately, addr 0x20 unchanged, all outputs 0.
REQ-032 Idle/no-req: no req for 10 cycles -> mem_read=mem_write=0, gnt=rvalid=0; DMA read then CPU write -> dma_rdata unchanged by the CPU write.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and port ids.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection for the CPU/DMA arbiter: round-robin history and the
// DMA starvation counter used by the fixed-priority mode.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic cpu_req,
  input  logic dma_req,
  output logic winner
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             last_grant_reg;
  logic [CNT_W-1:0] starve_cnt_reg;

  always_comb begin
    winner = PORT_CPU;
    if (cpu_req && dma_req) begin
      if (PRIO_MODE == 0)
        winner = (last_grant_reg == PORT_DMA) ? PORT_CPU : PORT_DMA;
      else
        winner = (starve_cnt_reg == LIMIT) ? PORT_DMA : PORT_CPU;
    end else if (dma_req) begin
      winner = PORT_DMA;
    end
  end

  // History only moves on cycles where an arbitration actually happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= PORT_DMA;
      starve_cnt_reg <= '0;
    end else if (arb_en) begin
      if (cpu_req || dma_req)
        last_grant_reg <= winner;
      if (!dma_req || winner == PORT_DMA)
        starve_cnt_reg <= '0;
      else if (starve_cnt_reg != LIMIT)
        starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU, DMA) arbiter for a single-ported data memory. Each access
// takes one IDLE arbitration cycle plus one ACCESS cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic       cpu_rvalid,
  output logic [7:0] cpu_rdata,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_gnt,
  output logic       dma_rvalid,
  output logic [7:0] dma_rdata,
  output logic       mem_write,
  output logic       mem_read,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  state_t     state_reg, state_next;
  logic       arb_en;
  logic       any_req;
  logic       winner;
  logic       in_access;
  logic       port_reg;
  logic       we_reg;
  logic [7:0] addr_reg;
  logic [7:0] wdata_reg;
  logic [7:0] cpu_rdata_reg, dma_rdata_reg;
  logic       cpu_rvalid_reg, dma_rvalid_reg;

  assign arb_en  = (state_reg == IDLE);
  assign any_req = cpu_req || dma_req;

  dmem_arb_pick #(
    .PRIO_MODE    (PRIO_MODE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (arb_en),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .winner  (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Strobes decode straight from the state register so an async reset
  // removes mem_write before the next edge can commit it.
  always_comb begin
    state_next = state_reg;
    in_access  = 1'b0;
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req)
          state_next = ACCESS;
      end
      ACCESS: begin
        state_next = IDLE;
        in_access  = 1'b1;
        cpu_gnt    = (port_reg == PORT_CPU);
        dma_gnt    = (port_reg == PORT_DMA);
        mem_write  = we_reg;
        mem_read   = !we_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_reg  <= PORT_CPU;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (arb_en && any_req) begin
      port_reg  <= winner;
      we_reg    <= (winner == PORT_DMA) ? dma_we    : cpu_we;
      addr_reg  <= (winner == PORT_DMA) ? dma_addr  : cpu_addr;
      wdata_reg <= (winner == PORT_DMA) ? dma_wdata : cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_reg  <= '0;
      dma_rdata_reg  <= '0;
      cpu_rvalid_reg <= 1'b0;
      dma_rvalid_reg <= 1'b0;
    end else begin
      cpu_rvalid_reg <= 1'b0;
      dma_rvalid_reg <= 1'b0;
      if (in_access && !we_reg) begin
        if (port_reg == PORT_CPU) begin
          cpu_rdata_reg  <= mem_rdata;
          cpu_rvalid_reg <= 1'b1;
        end else begin
          dma_rdata_reg  <= mem_rdata;
          dma_rvalid_reg <= 1'b1;
        end
      end
    end
  end

  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign cpu_rdata  = cpu_rdata_reg;
  assign dma_rdata  = dma_rdata_reg;
  assign cpu_rvalid = cpu_rvalid_reg;
  assign dma_rvalid = dma_rvalid_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: instance 0 is round-robin, instance 1 is CPU priority with
// STARVE_LIMIT=4; both share stimulus and each has its own memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  logic [1:0] cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_write, mem_read;
  logic [7:0] cpu_rdata [2];
  logic [7:0] dma_rdata [2];
  logic [7:0] mem_addr  [2];
  logic [7:0] mem_wdata [2];
  logic [7:0] mem_rdata [2];

  int n_checks = 0;
  int n_fail   = 0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [7:0] mem [256];
      always @(posedge clk) if (mem_write[gi]) mem[mem_addr[gi]] <= mem_wdata[gi];
      assign mem_rdata[gi] = mem[mem_addr[gi]];

      dmem_arbiter #(.PRIO_MODE(gi), .STARVE_LIMIT(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt[gi]),
        .cpu_rvalid (cpu_rvalid[gi]),
        .cpu_rdata  (cpu_rdata[gi]),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt[gi]),
        .dma_rvalid (dma_rvalid[gi]),
        .dma_rdata  (dma_rdata[gi]),
        .mem_write  (mem_write[gi]),
        .mem_read   (mem_read[gi]),
        .mem_addr   (mem_addr[gi]),
        .mem_wdata  (mem_wdata[gi]),
        .mem_rdata  (mem_rdata[gi])
      );
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // {cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_write, mem_read}
  function automatic logic [5:0] stat(input int d);
    return {cpu_gnt[d], cpu_rvalid[d], dma_gnt[d], dma_rvalid[d], mem_write[d], mem_read[d]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One single-requester access, checked on both instances.
  task automatic txn(input logic is_dma, input logic we, input logic [7:0] addr,
                     input logic [7:0] data, input logic [7:0] exp_rd);
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = data;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      check_eq("txn_gnt", {cpu_gnt[d], dma_gnt[d]}, is_dma ? 2'b01 : 2'b10);
      check_eq("txn_mem", {mem_write[d], mem_read[d], mem_addr[d]}, {we, !we, addr});
    end
    clear_reqs();
    tick();
    for (int d = 0; d < 2; d++) begin
      check_eq("txn_rvalid", {cpu_rvalid[d], dma_rvalid[d]},
               we ? 2'b00 : (is_dma ? 2'b01 : 2'b10));
      check_eq("txn_idle_strobes", {mem_write[d], mem_read[d]}, 2'b00);
      if (!we)
        check_eq("txn_rdata", is_dma ? dma_rdata[d] : cpu_rdata[d], exp_rd);
    end
    $display("txn %s %s addr=%02h data=%02h", is_dma ? "dma" : "cpu", we ? "wr" : "rd",
             addr, we ? data : exp_rd);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    tick();
    for (int d = 0; d < 2; d++) begin
      check_eq("reset_stat", stat(d), 6'b0);
      check_eq("reset_mem_bus", {mem_addr[d], mem_wdata[d]}, 16'h0000);
      check_eq("reset_rdata", {cpu_rdata[d], dma_rdata[d]}, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Seed memory contents used by later reads.
    txn(1'b0, 1'b1, 8'h01, 8'h11, 8'h00);
    txn(1'b0, 1'b1, 8'h02, 8'h22, 8'h00);
    txn(1'b0, 1'b1, 8'h20, 8'h77, 8'h00);

    // Both requesters held: d0 alternates C,D,C..; d1 gives DMA every 5th grant.
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h02;
    for (int i = 0; i < 10; i++) begin
      logic w0, w1;
      w0 = (i % 2 == 1);
      w1 = (i % 5 == 4);
      tick();
      check_eq("rr_gnt", {cpu_gnt[0], dma_gnt[0]}, w0 ? 2'b01 : 2'b10);
      check_eq("rr_access", {mem_read[0], mem_write[0], mem_addr[0]},
               {2'b10, w0 ? 8'h02 : 8'h01});
      check_eq("starve_gnt", {cpu_gnt[1], dma_gnt[1]}, w1 ? 2'b01 : 2'b10);
      tick();
      check_eq("rr_idle_read", mem_read[0], 1'b0);
      check_eq("rr_rvalid", {cpu_rvalid[0], dma_rvalid[0]}, w0 ? 2'b01 : 2'b10);
      check_eq("rr_rdata", w0 ? dma_rdata[0] : cpu_rdata[0], w0 ? 8'h22 : 8'h11);
      check_eq("starve_rvalid", {cpu_rvalid[1], dma_rvalid[1]}, w1 ? 2'b01 : 2'b10);
      $display("arb round %0d: rr=%s prio=%s", i, w0 ? "dma" : "cpu", w1 ? "dma" : "cpu");
    end
    clear_reqs();

    // CPU write then read back; rvalid lasts exactly one cycle.
    txn(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
    txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
    tick();
    check_eq("rvalid_one_cycle", cpu_rvalid[0], 1'b0);
    check_eq("rdata_hold", cpu_rdata[0], 8'hA5);

    // No requests: everything stays quiet.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_stat0", stat(0), 6'b0);
      check_eq("idle_stat1", stat(1), 6'b0);
    end

    // DMA read, then CPU write to the same address leaves dma_rdata alone.
    txn(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);
    txn(1'b0, 1'b1, 8'h10, 8'h5A, 8'h00);
    for (int d = 0; d < 2; d++) begin
      check_eq("dma_rdata_kept", dma_rdata[d], 8'hA5);
      check_eq("dma_rvalid_low", dma_rvalid[d], 1'b0);
    end

    // Reset in the middle of a DMA write must abort it.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h20; dma_wdata = 8'h3C;
    tick();
    check_eq("abort_pre_gnt", {dma_gnt[0], mem_write[0], mem_addr[0]}, {2'b11, 8'h20});
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("abort_stat", stat(d), 6'b0);
      check_eq("abort_mem_bus", {mem_addr[d], mem_wdata[d]}, 16'h0000);
      check_eq("abort_rdata", {cpu_rdata[d], dma_rdata[d]}, 16'h0000);
    end
    tick();
    check_eq("abort_no_commit0", g_dut[0].mem[8'h20], 8'h77);
    check_eq("abort_no_commit1", g_dut[1].mem[8'h20], 8'h77);
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
